// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix multiplier: PE state encoding
// and width derivations used by both the PE and the array top.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pe_state_e;

  function automatic int k_bits_f(input int max_k);
    return $clog2(max_k + 1);
  endfunction

  // Wide enough that max_k full-scale products never overflow.
  function automatic int o_bits_f(input int i_bits, input int max_k);
    return 2 * i_bits + $clog2(max_k);
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate: signed/unsigned product extended to
// O_BITS, added to the accumulator (or to zero when starting a new sum).
module pe_mac #(
  parameter int I_BITS = 8,
  parameter int O_BITS = 20
) (
  input  logic [I_BITS-1:0] i_a,
  input  logic [I_BITS-1:0] i_b,
  input  logic              i_mode,
  input  logic              i_clear,
  input  logic [O_BITS-1:0] i_acc,
  output logic [O_BITS-1:0] o_sum
);

  logic [2*I_BITS-1:0] prod_s;
  logic [O_BITS-1:0]   prod_ext_s;
  logic [O_BITS-1:0]   base_s;

  // Multiply at full width, then sign- or zero-extend to the accumulator width.
  always_comb begin
    prod_s     = '0;
    prod_ext_s = '0;
    if (i_mode) begin
      prod_s = $signed({{I_BITS{i_a[I_BITS-1]}}, i_a}) *
               $signed({{I_BITS{i_b[I_BITS-1]}}, i_b});
    end else begin
      prod_s = {{I_BITS{1'b0}}, i_a} * {{I_BITS{1'b0}}, i_b};
    end
    for (int i = 0; i < O_BITS; i++) begin
      if (i < 2 * I_BITS) begin
        prod_ext_s[i] = prod_s[i];
      end else begin
        prod_ext_s[i] = i_mode & prod_s[2*I_BITS-1];
      end
    end
    base_s = i_clear ? '0 : i_acc;
    o_sum  = base_s + prod_ext_s;
  end

endmodule

// File: rtl/systolic_pe_acc.sv
// Systolic-array processing element: forwards operands east/south and
// accumulates a runtime-programmable number of valid beats.
module systolic_pe_acc
  import systolic_pkg::*;
#(
  parameter int I_BITS = 8,
  parameter int MAX_K  = 16,
  parameter int K_BITS = k_bits_f(MAX_K),
  parameter int O_BITS = o_bits_f(I_BITS, MAX_K)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [K_BITS-1:0] i_k_len,
  input  logic              i_signed,
  input  logic              i_valid,
  input  logic [I_BITS-1:0] i_a,
  input  logic [I_BITS-1:0] i_b,
  output logic              o_valid,
  output logic [I_BITS-1:0] o_a,
  output logic [I_BITS-1:0] o_b,
  output logic [O_BITS-1:0] o_c,
  output logic              o_busy,
  output logic              o_done
);

  pe_state_e         state_q, state_d;
  logic [K_BITS-1:0] k_len_q, k_len_d;
  logic [K_BITS-1:0] count_q, count_d;
  logic              mode_q, mode_d;
  logic [O_BITS-1:0] acc_q, acc_d;
  logic              valid_q, valid_d;
  logic [I_BITS-1:0] a_q, a_d;
  logic [I_BITS-1:0] b_q, b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [K_BITS-1:0] k_eff_s;
  logic [K_BITS-1:0] count_inc_s;
  logic [O_BITS-1:0] sum_s;

  // A start beat must use the freshly presented mode, not the latched one.
  pe_mac #(.I_BITS(I_BITS), .O_BITS(O_BITS)) u_mac (
    .i_a     (i_a),
    .i_b     (i_b),
    .i_mode  (i_start ? i_signed : mode_q),
    .i_clear (i_start),
    .i_acc   (acc_q),
    .o_sum   (sum_s)
  );

  // Next-state, accumulate and forwarding logic.
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    count_d     = count_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    done_d      = 1'b0;
    valid_d     = i_valid;
    a_d         = i_valid ? i_a : a_q;
    b_d         = i_valid ? i_b : b_q;
    k_eff_s     = (i_k_len > K_BITS'(MAX_K)) ? K_BITS'(MAX_K) : i_k_len;
    count_inc_s = count_q + K_BITS'(1);

    if (i_start) begin
      k_len_d = k_eff_s;
      mode_d  = i_signed;
      acc_d   = '0;
      count_d = '0;
      if (k_eff_s == '0) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else if (i_valid) begin
        acc_d   = sum_s;
        count_d = K_BITS'(1);
        if (k_eff_s == K_BITS'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ACCUM;
        end
      end else begin
        state_d = ACCUM;
      end
    end else begin
      case (state_q)
        ACCUM: begin
          if (i_valid) begin
            acc_d   = sum_s;
            count_d = count_inc_s;
            if (count_inc_s == k_len_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ACCUM;
            end
          end else begin
            state_d = ACCUM;
          end
        end
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == ACCUM);
  end

  // State and output registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      k_len_q <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_valid = valid_q;
  assign o_a     = a_q;
  assign o_b     = b_q;
  assign o_c     = acc_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: doc/systolic_pe_acc.md
Name: systolic_pe_acc

Overview:
Next-generation systolic-array processing element. Forwards A/B operands east/south with a registered valid flag. Accumulates products over a runtime-programmable number of valid beats (i_k_len) instead of a fixed count, with a runtime signed/unsigned mode. Completion is a registered done pulse, and the result is held until the next start. Instantiated per cell of the NxN systolic matrix multiplier.

Parameters:
I_BITS, 8, operand width
MAX_K, 16, maximum accumulation length supported (>=1)
K_BITS, $clog2(MAX_K+1), width of length/counter fields (derived)
O_BITS, 2*I_BITS+$clog2(MAX_K), accumulator/result width (derived)

Ports:
i_clock  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-low reset
i_start  input  1  one-cycle pulse; clears accumulator, latches i_k_len/i_signed
i_k_len  input  K_BITS  beats to accumulate; sampled only with i_start; values >MAX_K clamp to MAX_K
i_signed  input  1  1 = two's-complement operands; sampled with i_start
i_valid  input  1  i_a/i_b qualify this cycle
i_a  input  I_BITS  west operand
i_b  input  I_BITS  north operand
o_valid  output  1  registered i_valid (to neighbours)
o_a  output  I_BITS  registered i_a
o_b  output  I_BITS  registered i_b
o_c  output  O_BITS  result; held stable outside ACCUM
o_busy  output  1  high while in ACCUM
o_done  output  1  one-cycle pulse when o_c becomes final

Behaviour:
- Reset (i_reset=0, async): o_valid=0, o_a=0, o_b=0, o_c=0, o_done=0, o_busy=0, count=0, state=IDLE.
- Forwarding is independent of state. Each cycle o_valid<=i_valid. When i_valid=1: o_a<=i_a and o_b<=i_b; otherwise o_a/o_b hold. Latency is 1 cycle.
- States: IDLE, ACCUM, DONE. o_busy = (state==ACCUM). o_done is registered high only in the cycle after entering DONE.
- IDLE/DONE with i_start=1:
  - Latch k_len=min(i_k_len,MAX_K) and mode=i_signed.
  - acc<=0 and count<=0.
  - If k_len==0: go to DONE, o_c=0, pulse o_done next cycle.
  - Else go to ACCUM. If i_valid is also 1 in the start cycle, that beat counts: acc<=product and count<=1. If k_len==1, go directly to DONE.
- ACCUM, i_valid=1: acc<=acc+product, count<=count+1. When count+1==k_len: go to DONE, o_done pulses next cycle.
- ACCUM, i_valid=0: hold (bubble).
- ACCUM, i_start=1: abort and restart per the start rules above; the current partial sum is discarded and no o_done is issued.
- Product is a full 2*I_BITS-bit product, sign-extended (mode=1) or zero-extended (mode=0) to O_BITS. The accumulator wraps modulo 2^O_BITS; O_BITS is sized so that MAX_K beats never overflow.
- o_c is the accumulator register. It is stable in IDLE/DONE, updates during ACCUM, and holds its final value until the next i_start.
- DONE is terminal until i_start; back-to-back start in the cycle after o_done is legal.
- i_k_len/i_signed changes outside a start cycle are ignored.

Decomposition:
- Shared package (systolic_pkg): state encoding localparams (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2), and helper functions for K_BITS/O_BITS derivation, shared with the array top.
- Sub-module pe_mac: a combinational signed/unsigned multiply with extension to O_BITS, plus the accumulate adder. The FSM, counter and forwarding registers stay in systolic_pe_acc.

Test Plan:
- Reset mid-ACCUM (after 2 of 4 beats): deassert reset -> all outputs 0, state IDLE, no o_done.
- Unsigned: start k_len=4, a={1,2,3,4}, b={5,6,7,8} contiguous from the start cycle -> o_c=70, o_done pulses exactly once on the cycle after the 4th beat, o_busy low afterwards.
- Signed with bubbles: start k_len=3, signed; beats (-3,4),(bubble),(2,-5),(bubble),(-1,-1) -> o_c = -21 (two's complement in O_BITS); o_a/o_b/o_valid track inputs with 1-cycle latency, holding during bubbles.
- Boundaries: k_len=0 -> o_c=0, o_done next cycle. k_len=MAX_K+3 -> accumulates exactly MAX_K beats. I_BITS=8 unsigned 255*255 over MAX_K=16 beats -> 1040400, no wrap.
- Restart: start k_len=4; after 2 beats, i_start with k_len=2; beats (1,1),(2,2) -> o_c=5, single o_done.
- Back-to-back: i_start in the cycle after o_done with new operands -> previous o_c held until start, new result correct; forwarding is uninterrupted throughout.
